regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- 32-entry general-purpose register file for the single-issue pipeline, directly downstream of the destination-register select mux.
- Consumes the selected write-register number and write-back data.
- Provides two combinational read ports with write-through bypass.
- Tracks a per-register pending-write scoreboard so the hazard unit can stall on reads of not-yet-written registers.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; number of registers = 2**ADDR_W

Ports:
- i_clk  input  1  system clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_wr_en  input  1  write-back enable
- i_wr_addr  input  ADDR_W  write-back register number (from destination select mux)
- i_wr_data  input  DATA_W  write-back data
- i_rs_addr  input  ADDR_W  read port A address
- i_rt_addr  input  ADDR_W  read port B address
- o_rs_data  output  DATA_W  read port A data
- o_rt_data  output  DATA_W  read port B data
- i_iss_en  input  1  instruction issued that will write a register
- i_iss_addr  input  ADDR_W  destination register of issued instruction
- i_flush  input  1  clear all pending bits (pipeline flush)
- o_rs_busy  output  1  read port A register has a pending write
- o_rt_busy  output  1  read port B register has a pending write
- o_pend_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (i_rst_n low, asynchronous): all registers cleared to 0, all pending bits cleared, o_pend_cnt = 0. All outputs go to 0 combinationally during reset. Release is synchronous to i_clk.
- Write: on rising edge with i_wr_en=1 and i_wr_addr != 0, reg[i_wr_addr] <= i_wr_data. Writes to register 0 are discarded; reg 0 always reads 0.
- Read: o_rs_data and o_rt_data are combinational (zero-cycle latency).
- Bypass: if i_wr_en=1, i_wr_addr == read address and address != 0, the read port returns i_wr_data in the same cycle (write-through).
- Read address 0 always returns 0, including when it is written that cycle.
- Scoreboard pending bits, pend[0] hardwired 0. Per edge, in priority order:
  1. i_flush=1: all pend bits cleared. A write in the same cycle still updates data.
  2. Else, i_wr_en=1 and i_wr_addr != 0: pend[i_wr_addr] <= 0.
  3. Then, i_iss_en=1 and i_iss_addr != 0: pend[i_iss_addr] <= 1. Set overrides clear when the same address is issued and written in the same cycle.
- i_iss_en in the same cycle as i_flush: the issue is ignored (flush wins).
- Issue to an already-pending register: bit stays 1, count unchanged; no error.
- Write to a non-pending register: data written, bit stays 0.
- o_rs_busy = pend[i_rs_addr] & ~(i_wr_en & i_wr_addr == i_rs_addr). A write-back landing this cycle resolves the hazard via the bypass. o_rt_busy is the same for port B.
- o_pend_cnt is a registered population count of pend, updated on the same edge as pend. Range 0..2**ADDR_W-1, so no overflow.

Test Plan:
- Reset: load reg 5=0xDEADBEEF, assert i_rst_n low mid-cycle -> o_rs_data (addr 5) = 0 immediately, o_pend_cnt = 0; after release reg 5 reads 0.
- Write/read plus reg 0: write 0x12345678 to reg 7, then read rs=7 -> 0x12345678. Write 0xFFFFFFFF to reg 0 -> rs=0 reads 0 in the same cycle and after.
- Bypass: reg 3 = 0xA; same cycle i_wr_en=1, addr 3, data 0xB, rs=3, rt=3 -> both read 0xB before the edge, 0xB after.
- Scoreboard: issue reg 9 -> next cycle rs=9 gives o_rs_busy=1, o_pend_cnt=1. Write reg 9 with rs=9 -> o_rs_busy=0 that cycle; next cycle o_pend_cnt=0.
- Simultaneous events: pend[4]=1; same cycle write reg 4 and issue reg 4 -> pend[4] stays 1, count 1. Then i_flush with i_iss_en to reg 6 -> all clear, count 0, pend[6]=0.
- Sweep: issue regs 1..31 on consecutive cycles -> o_pend_cnt reaches 31. Issue reg 0 -> count unchanged; rs=0 gives o_rs_busy=0.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// 32-entry register file with write-through bypass read ports and a
// per-register pending-write scoreboard feeding the hazard unit.
module regfile_wb_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  input  logic              i_flush,
  output logic              o_rs_busy,
  output logic              o_rt_busy,
  output logic [ADDR_W:0]   o_pend_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_pend;
  logic [ADDR_W:0]   r_pend_cnt;

  logic [NREG-1:0]   w_pend_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_wr_valid;
  logic              w_rs_hit;
  logic              w_rt_hit;

  assign w_wr_valid = i_wr_en && (i_wr_addr != '0);

  // Flush beats everything; within a non-flush cycle an issue re-sets a bit
  // that the same cycle's write-back would otherwise clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_flush) begin
      w_pend_nxt = '0;
    end else begin
      if (w_wr_valid) w_pend_nxt[i_wr_addr] = 1'b0;
      if (i_iss_en && (i_iss_addr != '0)) w_pend_nxt[i_iss_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_valid) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign w_rs_hit = i_wr_en && (i_wr_addr == i_rs_addr);
  assign w_rt_hit = i_wr_en && (i_wr_addr == i_rt_addr);

  // Reset gating keeps the bypass path from leaking i_wr_data while in reset.
  assign o_rs_data = (!i_rst_n || (i_rs_addr == '0)) ? '0 :
                     w_rs_hit ? i_wr_data : r_mem[i_rs_addr];
  assign o_rt_data = (!i_rst_n || (i_rt_addr == '0)) ? '0 :
                     w_rt_hit ? i_wr_data : r_mem[i_rt_addr];

  assign o_rs_busy  = i_rst_n && r_pend[i_rs_addr] && !w_rs_hit;
  assign o_rt_busy  = i_rst_n && r_pend[i_rt_addr] && !w_rt_hit;
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: data path, bypass, reg 0,
// scoreboard priorities and pending-count sweep.
module tb_regfile_wb_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              flush;
  logic              rs_busy;
  logic              rt_busy;
  logic [ADDR_W:0]   pend_cnt;

  int checks;
  int failures;

  regfile_wb_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rs_addr  (rs_addr),
    .i_rt_addr  (rt_addr),
    .o_rs_data  (rs_data),
    .o_rt_data  (rt_data),
    .i_iss_en   (iss_en),
    .i_iss_addr (iss_addr),
    .i_flush    (flush),
    .o_rs_busy  (rs_busy),
    .o_rt_busy  (rt_busy),
    .o_pend_cnt (pend_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic drive_iss(input logic [ADDR_W-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    idle();
    step();
    step();
    check("rst_cnt", 32'(pend_cnt), 32'd0);
    check("rst_rs_data", rs_data, 32'd0);
    rst_n = 1'b1;
    step();

    // reset test: load reg 5, mark reg 2 pending, then reset mid-cycle
    drive_wr(5'd5, 32'hDEADBEEF);
    drive_iss(5'd2);
    step();
    idle();
    rs_addr = 5'd5;
    rt_addr = 5'd2;
    settle();
    check("pre_rst_rs5", rs_data, 32'hDEADBEEF);
    check("pre_rst_cnt", 32'(pend_cnt), 32'd1);
    check("pre_rst_rt_busy", 32'(rt_busy), 32'd1);
    rst_n = 1'b0;
    settle();
    check("mid_rst_rs5", rs_data, 32'd0);
    check("mid_rst_cnt", 32'(pend_cnt), 32'd0);
    check("mid_rst_rt_busy", 32'(rt_busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_rs5", rs_data, 32'd0);

    // write / read and register 0
    drive_wr(5'd7, 32'h12345678);
    step();
    idle();
    rs_addr = 5'd7;
    settle();
    check("rd_r7", rs_data, 32'h12345678);
    check("wr_nonpend_cnt", 32'(pend_cnt), 32'd0);
    drive_wr(5'd0, 32'hFFFFFFFF);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    settle();
    check("r0_same_rs", rs_data, 32'd0);
    check("r0_same_rt", rt_data, 32'd0);
    step();
    idle();
    settle();
    check("r0_after", rs_data, 32'd0);

    // bypass
    drive_wr(5'd3, 32'hA);
    step();
    drive_wr(5'd3, 32'hB);
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    settle();
    check("byp_rs", rs_data, 32'hB);
    check("byp_rt", rt_data, 32'hB);
    rt_addr = 5'd7;
    settle();
    check("byp_other_rt", rt_data, 32'h12345678);
    step();
    idle();
    rt_addr = 5'd3;
    settle();
    check("byp_after_rs", rs_data, 32'hB);
    check("byp_after_rt", rt_data, 32'hB);

    // scoreboard: issue then resolve via write-back
    drive_iss(5'd9);
    step();
    idle();
    rs_addr = 5'd9;
    settle();
    check("sb_busy", 32'(rs_busy), 32'd1);
    check("sb_cnt1", 32'(pend_cnt), 32'd1);
    drive_wr(5'd9, 32'h99);
    settle();
    check("sb_wb_busy", 32'(rs_busy), 32'd0);
    check("sb_wb_data", rs_data, 32'h99);
    step();
    idle();
    settle();
    check("sb_cnt0", 32'(pend_cnt), 32'd0);
    check("sb_after_busy", 32'(rs_busy), 32'd0);

    // simultaneous write + issue to same reg, then flush vs issue
    drive_iss(5'd4);
    step();
    idle();
    drive_wr(5'd4, 32'h44);
    drive_iss(5'd4);
    step();
    idle();
    rs_addr = 5'd4;
    settle();
    check("sim_busy4", 32'(rs_busy), 32'd1);
    check("sim_cnt1", 32'(pend_cnt), 32'd1);
    check("sim_data4", rs_data, 32'h44);
    flush = 1'b1;
    drive_iss(5'd6);
    drive_wr(5'd8, 32'h88);
    step();
    idle();
    rs_addr = 5'd6;
    rt_addr = 5'd4;
    settle();
    check("fl_busy6", 32'(rs_busy), 32'd0);
    check("fl_busy4", 32'(rt_busy), 32'd0);
    check("fl_cnt", 32'(pend_cnt), 32'd0);
    rs_addr = 5'd8;
    settle();
    check("fl_wr_data", rs_data, 32'h88);

    // sweep: issue 1..31
    for (int a = 1; a < 32; a++) begin
      drive_iss(5'(a));
      step();
    end
    idle();
    settle();
    check("sweep_cnt31", 32'(pend_cnt), 32'd31);
    drive_iss(5'd5);
    step();
    idle();
    settle();
    check("reissue_cnt", 32'(pend_cnt), 32'd31);
    drive_iss(5'd0);
    step();
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd31;
    settle();
    check("iss0_cnt", 32'(pend_cnt), 32'd31);
    check("iss0_busy", 32'(rs_busy), 32'd0);
    check("r31_busy", 32'(rt_busy), 32'd1);
    rt_addr = 5'd10;
    drive_wr(5'd10, 32'h1010);
    settle();
    check("r10_wb_busy", 32'(rt_busy), 32'd0);
    step();
    idle();
    settle();
    check("r10_cnt30", 32'(pend_cnt), 32'd30);
    check("r10_data", rt_data, 32'h1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
